// File: rtl/round_controller.sv
// Fighting-game round sequencer: countdown, hitbox/hurtbox hit detection with hitstop, round and match scoring.
// Define ROUND_TIMER_EN to enable the per-round clock; without it timer_sec reads 0 and rounds never time out.
module round_controller #(
    parameter int HEALTH_INIT      = 3,
    parameter int ROUNDS_TO_WIN    = 2,
    parameter int COUNTDOWN_FRAMES = 180,
    parameter int HITSTOP_FRAMES   = 8,
    parameter int KO_FRAMES        = 120,
    parameter int ROUND_SECONDS    = 99,
    parameter int FRAMES_PER_SEC   = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       p1_hit_active,
    input  logic       p2_hit_active,
    input  logic [9:0] p1_hit_x1,
    input  logic [9:0] p1_hit_x2,
    input  logic [9:0] p1_hit_y1,
    input  logic [9:0] p1_hit_y2,
    input  logic [9:0] p2_hit_x1,
    input  logic [9:0] p2_hit_x2,
    input  logic [9:0] p2_hit_y1,
    input  logic [9:0] p2_hit_y2,
    input  logic [9:0] p1_hurt_x1,
    input  logic [9:0] p1_hurt_x2,
    input  logic [9:0] p1_hurt_y1,
    input  logic [9:0] p1_hurt_y2,
    input  logic [9:0] p2_hurt_x1,
    input  logic [9:0] p2_hurt_x2,
    input  logic [9:0] p2_hurt_y1,
    input  logic [9:0] p2_hurt_y2,
    output logic [3:0] p1_health,
    output logic [3:0] p2_health,
    output logic [1:0] p1_rounds,
    output logic [1:0] p2_rounds,
    output logic [2:0] state,
    output logic [6:0] timer_sec,
    output logic       p1_hit_pulse,
    output logic       p2_hit_pulse,
    output logic       freeze,
    output logic [1:0] winner
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        FIGHT     = 3'd2,
        HITSTOP   = 3'd3,
        ROUND_END = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    localparam logic [3:0]  HEALTH_LOAD  = 4'(HEALTH_INIT);
    localparam logic [1:0]  ROUNDS_MAX   = 2'(ROUNDS_TO_WIN);
    localparam logic [6:0]  SECONDS_LOAD = 7'(ROUND_SECONDS);
    localparam logic [15:0] CD_LAST      = 16'(COUNTDOWN_FRAMES - 1);
    localparam logic [15:0] HS_LAST      = 16'(HITSTOP_FRAMES - 1);
    localparam logic [15:0] KO_LAST      = 16'(KO_FRAMES - 1);
    localparam logic [15:0] SEC_LAST     = 16'(FRAMES_PER_SEC - 1);

    function automatic logic overlap(input logic [9:0] hx1, hx2, hy1, hy2, ux1, ux2, uy1, uy2);
        return (hx1 <= ux2) && (ux1 <= hx2) && (hy1 <= uy2) && (uy1 <= hy2);
    endfunction

    function automatic logic [3:0] dec_sat(input logic [3:0] h);
        return (h == 4'd0) ? 4'd0 : h - 4'd1;
    endfunction

    state_t      state_r, state_s;
    logic [3:0]  p1_health_r, p1_health_s, p2_health_r, p2_health_s;
    logic [1:0]  p1_rounds_r, p1_rounds_s, p2_rounds_r, p2_rounds_s;
    logic [1:0]  winner_r, winner_s, award_win_s, award_r1_s, award_r2_s;
    logic [6:0]  timer_r, timer_s;
    logic [15:0] frame_cnt_r, frame_cnt_s, sec_cnt_r, sec_cnt_s;
    logic        p1_used_r, p1_used_s, p2_used_r, p2_used_s;
    logic        p1_pulse_r, p1_pulse_s, p2_pulse_r, p2_pulse_s;
    logic        freeze_r, timer_en_s, p1_lands_s, p2_lands_s;

`ifdef ROUND_TIMER_EN
    assign timer_en_s = 1'b1;
`else
    assign timer_en_s = 1'b0;
`endif

    // An attack lands only once per activation: the consumed flag blocks repeats
    assign p1_lands_s = p1_hit_active && !p1_used_r &&
        overlap(p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2, p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2);
    assign p2_lands_s = p2_hit_active && !p2_used_r &&
        overlap(p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2, p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2);

    // Round award from the healths standing when the round ends
    always_comb begin
        award_r1_s  = p1_rounds_r;
        award_r2_s  = p2_rounds_r;
        award_win_s = 2'd3;
        if (p1_health_r > p2_health_r) begin
            award_win_s = 2'd1;
            award_r1_s  = (p1_rounds_r >= ROUNDS_MAX) ? ROUNDS_MAX : p1_rounds_r + 2'd1;
        end else if (p2_health_r > p1_health_r) begin
            award_win_s = 2'd2;
            award_r2_s  = (p2_rounds_r >= ROUNDS_MAX) ? ROUNDS_MAX : p2_rounds_r + 2'd1;
        end else begin
            award_win_s = 2'd3;
        end
    end

    // Next-state and next-value logic for the match sequencer
    always_comb begin
        state_s     = state_r;
        p1_health_s = p1_health_r;
        p2_health_s = p2_health_r;
        p1_rounds_s = p1_rounds_r;
        p2_rounds_s = p2_rounds_r;
        winner_s    = winner_r;
        timer_s     = timer_r;
        frame_cnt_s = frame_cnt_r;
        sec_cnt_s   = sec_cnt_r;
        p1_pulse_s  = 1'b0;
        p2_pulse_s  = 1'b0;
        if (frame_tick && !p1_hit_active) p1_used_s = 1'b0;
        else                              p1_used_s = p1_used_r;
        if (frame_tick && !p2_hit_active) p2_used_s = 1'b0;
        else                              p2_used_s = p2_used_r;

        case (state_r)
            IDLE, GAME_OVER: begin
                if (start) begin
                    state_s     = COUNTDOWN;
                    p1_health_s = HEALTH_LOAD;
                    p2_health_s = HEALTH_LOAD;
                    p1_rounds_s = 2'd0;
                    p2_rounds_s = 2'd0;
                    winner_s    = 2'd0;
                    timer_s     = SECONDS_LOAD;
                    frame_cnt_s = 16'd0;
                    sec_cnt_s   = 16'd0;
                    p1_used_s   = 1'b0;
                    p2_used_s   = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            COUNTDOWN: begin
                if (frame_tick && frame_cnt_r == CD_LAST) begin
                    state_s     = FIGHT;
                    frame_cnt_s = 16'd0;
                end else if (frame_tick) begin
                    frame_cnt_s = frame_cnt_r + 16'd1;
                end else begin
                    frame_cnt_s = frame_cnt_r;
                end
            end
            FIGHT: begin
                if (frame_tick && (p1_lands_s || p2_lands_s)) begin
                    state_s     = HITSTOP;
                    frame_cnt_s = 16'd0;
                    if (p1_lands_s) begin
                        p2_health_s = dec_sat(p2_health_r);
                        p2_pulse_s  = 1'b1;
                        p1_used_s   = 1'b1;
                    end else begin
                        p2_pulse_s = 1'b0;
                    end
                    if (p2_lands_s) begin
                        p1_health_s = dec_sat(p1_health_r);
                        p1_pulse_s  = 1'b1;
                        p2_used_s   = 1'b1;
                    end else begin
                        p1_pulse_s = 1'b0;
                    end
                end else if (frame_tick && sec_cnt_r == SEC_LAST) begin
                    sec_cnt_s = 16'd0;
                    timer_s   = (timer_r == 7'd0) ? 7'd0 : timer_r - 7'd1;
                    if (timer_en_s && timer_r == 7'd1) begin
                        state_s     = ROUND_END;
                        frame_cnt_s = 16'd0;
                        winner_s    = award_win_s;
                        p1_rounds_s = award_r1_s;
                        p2_rounds_s = award_r2_s;
                    end else begin
                        state_s = FIGHT;
                    end
                end else if (frame_tick) begin
                    sec_cnt_s = sec_cnt_r + 16'd1;
                end else begin
                    sec_cnt_s = sec_cnt_r;
                end
            end
            HITSTOP: begin
                if (frame_tick && frame_cnt_r == HS_LAST) begin
                    frame_cnt_s = 16'd0;
                    if (p1_health_r == 4'd0 || p2_health_r == 4'd0) begin
                        state_s     = ROUND_END;
                        winner_s    = award_win_s;
                        p1_rounds_s = award_r1_s;
                        p2_rounds_s = award_r2_s;
                    end else begin
                        state_s = FIGHT;
                    end
                end else if (frame_tick) begin
                    frame_cnt_s = frame_cnt_r + 16'd1;
                end else begin
                    frame_cnt_s = frame_cnt_r;
                end
            end
            ROUND_END: begin
                if (frame_tick && frame_cnt_r == KO_LAST) begin
                    frame_cnt_s = 16'd0;
                    if (p1_rounds_r == ROUNDS_MAX) begin
                        state_s  = GAME_OVER;
                        winner_s = 2'd1;
                    end else if (p2_rounds_r == ROUNDS_MAX) begin
                        state_s  = GAME_OVER;
                        winner_s = 2'd2;
                    end else begin
                        state_s     = COUNTDOWN;
                        p1_health_s = HEALTH_LOAD;
                        p2_health_s = HEALTH_LOAD;
                        timer_s     = SECONDS_LOAD;
                        sec_cnt_s   = 16'd0;
                        winner_s    = 2'd0;
                    end
                end else if (frame_tick) begin
                    frame_cnt_s = frame_cnt_r + 16'd1;
                end else begin
                    frame_cnt_s = frame_cnt_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; freeze is registered from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            p1_health_r <= HEALTH_LOAD;
            p2_health_r <= HEALTH_LOAD;
            p1_rounds_r <= 2'd0;
            p2_rounds_r <= 2'd0;
            winner_r    <= 2'd0;
            timer_r     <= SECONDS_LOAD;
            frame_cnt_r <= 16'd0;
            sec_cnt_r   <= 16'd0;
            p1_used_r   <= 1'b0;
            p2_used_r   <= 1'b0;
            p1_pulse_r  <= 1'b0;
            p2_pulse_r  <= 1'b0;
            freeze_r    <= 1'b1;
        end else begin
            state_r     <= state_s;
            p1_health_r <= p1_health_s;
            p2_health_r <= p2_health_s;
            p1_rounds_r <= p1_rounds_s;
            p2_rounds_r <= p2_rounds_s;
            winner_r    <= winner_s;
            timer_r     <= timer_s;
            frame_cnt_r <= frame_cnt_s;
            sec_cnt_r   <= sec_cnt_s;
            p1_used_r   <= p1_used_s;
            p2_used_r   <= p2_used_s;
            p1_pulse_r  <= p1_pulse_s;
            p2_pulse_r  <= p2_pulse_s;
            freeze_r    <= (state_s != FIGHT);
        end
    end

    assign state        = state_r;
    assign p1_health    = p1_health_r;
    assign p2_health    = p2_health_r;
    assign p1_rounds    = p1_rounds_r;
    assign p2_rounds    = p2_rounds_r;
    assign winner       = winner_r;
    assign timer_sec    = timer_en_s ? timer_r : 7'd0;
    assign p1_hit_pulse = p1_pulse_r;
    assign p2_hit_pulse = p2_pulse_r;
    assign freeze       = freeze_r;
endmodule

// File: tb/tb_round_controller.sv
// Self-checking bench for round_controller: directed match scenarios plus randomized play,
// compared every cycle against a frame-level behavioural model of the match rules.
module tb_round_controller;
    logic       clk = 1'b0;
    logic       rst, frame_tick, start, p1_hit_active, p2_hit_active;
    logic [9:0] p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2;
    logic [9:0] p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2;
    logic [9:0] p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2;
    logic [9:0] p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2;
    logic [3:0] p1_health, p2_health;
    logic [1:0] p1_rounds, p2_rounds, winner;
    logic [2:0] state;
    logic [6:0] timer_sec;
    logic       p1_hit_pulse, p2_hit_pulse, freeze;

    always #5 clk = ~clk;

    round_controller dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .p1_hit_active(p1_hit_active), .p2_hit_active(p2_hit_active),
        .p1_hit_x1(p1_hit_x1), .p1_hit_x2(p1_hit_x2), .p1_hit_y1(p1_hit_y1), .p1_hit_y2(p1_hit_y2),
        .p2_hit_x1(p2_hit_x1), .p2_hit_x2(p2_hit_x2), .p2_hit_y1(p2_hit_y1), .p2_hit_y2(p2_hit_y2),
        .p1_hurt_x1(p1_hurt_x1), .p1_hurt_x2(p1_hurt_x2), .p1_hurt_y1(p1_hurt_y1), .p1_hurt_y2(p1_hurt_y2),
        .p2_hurt_x1(p2_hurt_x1), .p2_hurt_x2(p2_hurt_x2), .p2_hurt_y1(p2_hurt_y1), .p2_hurt_y2(p2_hurt_y2),
        .p1_health(p1_health), .p2_health(p2_health), .p1_rounds(p1_rounds), .p2_rounds(p2_rounds),
        .state(state), .timer_sec(timer_sec), .p1_hit_pulse(p1_hit_pulse), .p2_hit_pulse(p2_hit_pulse),
        .freeze(freeze), .winner(winner)
    );

`ifdef ROUND_TIMER_EN
    localparam int TL = 99;
`else
    localparam int TL = 0;
`endif

    int checks = 0;
    int errors = 0;

    // Match model: phase number, frames left in the timed phase, scores
    int m_state, m_h1, m_h2, m_r1, m_r2, m_win, m_left, m_timer, m_secleft;
    bit m_c1, m_c2, m_p1, m_p2;

    function automatic bit ovl(int hx1, int hx2, int hy1, int hy2, int ux1, int ux2, int uy1, int uy2);
        return (hx1 <= ux2) && (ux1 <= hx2) && (hy1 <= uy2) && (uy1 <= hy2);
    endfunction

    task automatic m_reset();
        m_state = 0; m_h1 = 3; m_h2 = 3; m_r1 = 0; m_r2 = 0; m_win = 0;
        m_left = 0; m_timer = TL; m_secleft = 60;
        m_c1 = 1'b0; m_c2 = 1'b0; m_p1 = 1'b0; m_p2 = 1'b0;
    endtask

    task automatic m_end_round();
        m_state = 4; m_left = 120;
        if (m_h1 > m_h2) begin
            m_win = 1; m_r1 = (m_r1 >= 2) ? 2 : m_r1 + 1;
        end else if (m_h2 > m_h1) begin
            m_win = 2; m_r2 = (m_r2 >= 2) ? 2 : m_r2 + 1;
        end else begin
            m_win = 3;
        end
    endtask

    task automatic m_step();
        bit l1, l2;
        m_p1 = 1'b0; m_p2 = 1'b0;
        if (frame_tick && !p1_hit_active) m_c1 = 1'b0;
        if (frame_tick && !p2_hit_active) m_c2 = 1'b0;
        case (m_state)
            0, 5: if (start) begin
                m_state = 1; m_left = 180; m_h1 = 3; m_h2 = 3; m_r1 = 0; m_r2 = 0; m_win = 0;
                m_timer = TL; m_secleft = 60; m_c1 = 1'b0; m_c2 = 1'b0;
            end
            1: if (frame_tick) begin
                m_left--;
                if (m_left == 0) m_state = 2;
            end
            2: if (frame_tick) begin
                l1 = p1_hit_active && !m_c1 && ovl(p1_hit_x1, p1_hit_x2, p1_hit_y1, p1_hit_y2,
                                                  p2_hurt_x1, p2_hurt_x2, p2_hurt_y1, p2_hurt_y2);
                l2 = p2_hit_active && !m_c2 && ovl(p2_hit_x1, p2_hit_x2, p2_hit_y1, p2_hit_y2,
                                                  p1_hurt_x1, p1_hurt_x2, p1_hurt_y1, p1_hurt_y2);
                if (l1 || l2) begin
                    if (l1) begin m_h2 = (m_h2 > 0) ? m_h2 - 1 : 0; m_p2 = 1'b1; m_c1 = 1'b1; end
                    if (l2) begin m_h1 = (m_h1 > 0) ? m_h1 - 1 : 0; m_p1 = 1'b1; m_c2 = 1'b1; end
                    m_state = 3; m_left = 8;
                end else begin
`ifdef ROUND_TIMER_EN
                    m_secleft--;
                    if (m_secleft == 0) begin
                        m_secleft = 60;
                        if (m_timer > 0) m_timer--;
                        if (m_timer == 0) m_end_round();
                    end
`endif
                end
            end
            3: if (frame_tick) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_h1 == 0 || m_h2 == 0) m_end_round();
                    else m_state = 2;
                end
            end
            4: if (frame_tick) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_r1 == 2) begin m_state = 5; m_win = 1; end
                    else if (m_r2 == 2) begin m_state = 5; m_win = 2; end
                    else begin
                        m_state = 1; m_left = 180; m_h1 = 3; m_h2 = 3;
                        m_timer = TL; m_secleft = 60; m_win = 0;
                    end
                end
            end
            default: m_state = 0;
        endcase
    endtask

    // Advance the model from the inputs held over the last rising edge, then compare
    always @(negedge clk) begin
        if (!rst) m_reset();
        else      m_step();
        checks++;
        if (state !== 3'(m_state) || p1_health !== 4'(m_h1) || p2_health !== 4'(m_h2) ||
            p1_rounds !== 2'(m_r1) || p2_rounds !== 2'(m_r2) || winner !== 2'(m_win) ||
            timer_sec !== 7'(m_timer) || p1_hit_pulse !== m_p1 || p2_hit_pulse !== m_p2 ||
            freeze !== (m_state != 2)) begin
            errors++;
            $display("FAIL model_cmp t=%0t got st=%0d h=%0d/%0d r=%0d/%0d w=%0d t=%0d p=%0b%0b f=%0b want st=%0d h=%0d/%0d r=%0d/%0d w=%0d t=%0d p=%0b%0b f=%0b",
                     $time, state, p1_health, p2_health, p1_rounds, p2_rounds, winner, timer_sec,
                     p1_hit_pulse, p2_hit_pulse, freeze, m_state, m_h1, m_h2, m_r1, m_r2, m_win,
                     m_timer, m_p1, m_p2, m_state != 2);
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(bit t);
        frame_tick = t;
        @(negedge clk);
        #1;
    endtask

    task automatic tick(int n);
        repeat (n) begin
            cyc(1'b1);
            cyc(1'b0);
        end
    endtask

    task automatic set_boxes();
        p1_hit_x1 = 10'd100; p1_hit_x2 = 10'd150; p1_hit_y1 = 10'd200; p1_hit_y2 = 10'd220;
        p2_hurt_x1 = 10'd140; p2_hurt_x2 = 10'd200; p2_hurt_y1 = 10'd180; p2_hurt_y2 = 10'd300;
        p2_hit_x1 = 10'd300; p2_hit_x2 = 10'd350; p2_hit_y1 = 10'd200; p2_hit_y2 = 10'd220;
        p1_hurt_x1 = 10'd320; p1_hurt_x2 = 10'd400; p1_hurt_y1 = 10'd180; p1_hurt_y2 = 10'd300;
    endtask

    task automatic p1_strike();
        p1_hit_active = 1'b1; tick(1);
        p1_hit_active = 1'b0; tick(8);
    endtask

    task automatic p2_strike();
        p2_hit_active = 1'b1; tick(1);
        p2_hit_active = 1'b0; tick(8);
    endtask

    initial begin
        rst = 1'b0; frame_tick = 1'b0; start = 1'b0;
        p1_hit_active = 1'b0; p2_hit_active = 1'b0;
        set_boxes();
        cyc(1'b0); cyc(1'b0);
        chk("reset_state", int'(state), 0);
        chk("reset_freeze", int'(freeze), 1);
        chk("reset_health", int'(p1_health) * 16 + int'(p2_health), 3 * 16 + 3);
        chk("reset_timer", int'(timer_sec), TL);
        chk("reset_winner", int'(winner), 0);
        rst = 1'b1; cyc(1'b0);

        // Countdown into the first round
        start = 1'b1; cyc(1'b0); start = 1'b0;
        chk("start_state", int'(state), 1);
        tick(179);
        chk("countdown_179", int'(state), 1);
        tick(1);
        chk("fight_state", int'(state), 2);
        chk("fight_freeze", int'(freeze), 0);
        chk("fight_timer", int'(timer_sec), TL);
        chk("fight_health", int'(p1_health) * 16 + int'(p2_health), 3 * 16 + 3);

        // Single hit, hitstop length, held attack lands once
        p1_hit_active = 1'b1; cyc(1'b1);
        chk("hit_pulse_on", int'(p2_hit_pulse), 1);
        chk("hit_p2_health", int'(p2_health), 2);
        chk("hit_state", int'(state), 3);
        cyc(1'b0);
        chk("hit_pulse_off", int'(p2_hit_pulse), 0);
        tick(7);
        chk("hitstop_7", int'(state), 3);
        tick(1);
        chk("hitstop_done", int'(state), 2);
        tick(30);
        chk("held_no_rehit", int'(p2_health), 2);
        p1_hit_active = 1'b0; tick(1);
        p1_hit_active = 1'b1; tick(1);
        chk("reassert_hit", int'(p2_health), 1);
        p1_hit_active = 1'b0; tick(8);
        p1_strike();
        chk("ko_state", int'(state), 4);
        chk("ko_winner", int'(winner), 1);
        chk("ko_rounds", int'(p1_rounds), 1);
        tick(120);
        chk("round2_state", int'(state), 1);
        chk("round2_health", int'(p2_health), 3);
        tick(180);
        repeat (3) p1_strike();
        chk("ko2_rounds", int'(p1_rounds), 2);
        tick(120);
        chk("gameover_state", int'(state), 5);
        chk("gameover_winner", int'(winner), 1);

        // Restart, then double KO trade at 1/1
        start = 1'b1; cyc(1'b0); start = 1'b0;
        chk("restart_state", int'(state), 1);
        chk("restart_rounds", int'(p1_rounds) * 4 + int'(p2_rounds), 0);
        tick(180);
        repeat (2) p1_strike();
        repeat (2) p2_strike();
        chk("pre_trade_health", int'(p1_health) * 16 + int'(p2_health), 1 * 16 + 1);
        p1_hit_active = 1'b1; p2_hit_active = 1'b1; cyc(1'b1);
        chk("trade_pulses", int'(p1_hit_pulse) * 2 + int'(p2_hit_pulse), 3);
        chk("trade_health", int'(p1_health) * 16 + int'(p2_health), 0);
        cyc(1'b0);
        p1_hit_active = 1'b0; p2_hit_active = 1'b0;
        tick(8);
        chk("trade_state", int'(state), 4);
        chk("trade_winner", int'(winner), 3);
        chk("trade_rounds", int'(p1_rounds) * 4 + int'(p2_rounds), 0);

        // Randomized play checked cycle by cycle against the model
        for (int i = 0; i < 20000; i++) begin
            p1_hit_x1 = 10'($urandom_range(0, 40)); p1_hit_x2 = p1_hit_x1 + 10'($urandom_range(0, 30));
            p1_hit_y1 = 10'($urandom_range(0, 40)); p1_hit_y2 = p1_hit_y1 + 10'($urandom_range(0, 30));
            p2_hit_x1 = 10'($urandom_range(0, 40)); p2_hit_x2 = p2_hit_x1 + 10'($urandom_range(0, 30));
            p2_hit_y1 = 10'($urandom_range(0, 40)); p2_hit_y2 = p2_hit_y1 + 10'($urandom_range(0, 30));
            p1_hurt_x1 = 10'($urandom_range(0, 40)); p1_hurt_x2 = p1_hurt_x1 + 10'($urandom_range(0, 30));
            p1_hurt_y1 = 10'($urandom_range(0, 40)); p1_hurt_y2 = p1_hurt_y1 + 10'($urandom_range(0, 30));
            p2_hurt_x1 = 10'($urandom_range(0, 40)); p2_hurt_x2 = p2_hurt_x1 + 10'($urandom_range(0, 30));
            p2_hurt_y1 = 10'($urandom_range(0, 40)); p2_hurt_y2 = p2_hurt_y1 + 10'($urandom_range(0, 30));
            p1_hit_active = ($urandom_range(0, 3) != 0);
            p2_hit_active = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 99) == 0);
            rst = ($urandom_range(0, 4999) != 0);
            cyc(1'($urandom_range(0, 1)));
        end

        // Reset asserted in the middle of hitstop
        start = 1'b0; p1_hit_active = 1'b0; p2_hit_active = 1'b0; set_boxes();
        rst = 1'b0; cyc(1'b0);
        rst = 1'b1; cyc(1'b0);
        start = 1'b1; cyc(1'b0); start = 1'b0;
        tick(180);
        p1_hit_active = 1'b1; tick(1);
        p1_hit_active = 1'b0; tick(3);
        chk("mid_hitstop", int'(state), 3);
        rst = 1'b0;
        #1;
        chk("async_reset_state", int'(state), 0);
        chk("async_reset_freeze", int'(freeze), 1);
        chk("async_reset_health", int'(p2_health), 3);
        cyc(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
